// File: rtl/seg7_capture_monitor.sv
// Monitors a multiplexed, active-low 7-segment display bus. Each digit pattern has to stay
// stable for STABLE_CYCLES synchronized cycles before it is decoded into a nibble.
// Optional feature macro: SEG7_DP_CAPTURE_EN adds a per-digit decimal-point output (dp).
module seg7_capture_monitor #(
    parameter int unsigned STABLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  seg,
    input  logic [3:0]  an,
    input  logic        clear,
    output logic [15:0] digits,
    output logic [3:0]  valid,
    output logic        upd,
    output logic [1:0]  upd_idx,
    output logic        bad_pat,
    output logic [7:0]  err_cnt
`ifdef SEG7_DP_CAPTURE_EN
    ,
    output logic [3:0]  dp
`endif
);

`ifdef SEG7_DP_CAPTURE_EN
    // dp is part of the key, so a change of dp restarts the dwell.
    localparam int unsigned SegW = 8;
`else
    localparam int unsigned SegW = 7;
    logic unused_seg7;
    assign unused_seg7 = seg[7];
`endif
    localparam int unsigned KeyW = SegW + 4;
    localparam logic [7:0] CapCnt  = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0] HeldCnt = 8'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        StIdle,
        StTrack,
        StHeld
    } state_e;

    logic [SegW-1:0] seg_s1_q, seg_s2_q;
    logic [3:0]      an_s1_q, an_s2_q;
    logic [KeyW-1:0] key, key_prev_q;
    state_e          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            capture;
    logic            an_onehot;
    logic [1:0]      idx;
    logic [3:0]      nib;
    logic            pat_legal, pat_blank;

    logic [15:0]     digits_q;
    logic [3:0]      valid_q;
    logic            upd_q, bad_q;
    logic [1:0]      upd_idx_q;
    logic [7:0]      err_q;
`ifdef SEG7_DP_CAPTURE_EN
    logic [3:0]      dp_q;
`endif

    assign key = {an_s2_q, seg_s2_q};

    // Two-flop synchronizers; idle bus (all ones) is the reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1_q <= '1;
            seg_s2_q <= '1;
            an_s1_q  <= '1;
            an_s2_q  <= '1;
        end else begin
            seg_s1_q <= seg[SegW-1:0];
            seg_s2_q <= seg_s1_q;
            an_s1_q  <= an;
            an_s2_q  <= an_s1_q;
        end
    end

    // Anode decode: exactly one active-low enable selects a digit.
    always_comb begin
        an_onehot = 1'b1;
        idx       = 2'd0;
        unique case (an_s2_q)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: an_onehot = 1'b0;
        endcase
    end

    // Segment pattern decode (active-low g..a).
    always_comb begin
        nib       = 4'h0;
        pat_legal = 1'b1;
        pat_blank = 1'b0;
        unique case (seg_s2_q[6:0])
            7'h40: nib = 4'h0;
            7'h79: nib = 4'h1;
            7'h24: nib = 4'h2;
            7'h30: nib = 4'h3;
            7'h19: nib = 4'h4;
            7'h12: nib = 4'h5;
            7'h02: nib = 4'h6;
            7'h78: nib = 4'h7;
            7'h00: nib = 4'h8;
            7'h10: nib = 4'h9;
            7'h08: nib = 4'hA;
            7'h03: nib = 4'hB;
            7'h46: nib = 4'hC;
            7'h21: nib = 4'hD;
            7'h06: nib = 4'hE;
            7'h0E: nib = 4'hF;
            7'h7F: begin
                pat_legal = 1'b0;
                pat_blank = 1'b1;
            end
            default: pat_legal = 1'b0;
        endcase
    end

    // FSM next state and stability counter; capture fires once per dwell.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        if (clear || !an_onehot) begin
            state_d = StIdle;
            cnt_d   = 8'd0;
        end else if (key != key_prev_q) begin
            state_d = StTrack;
            cnt_d   = 8'd1;
        end else if (state_q == StTrack) begin
            if (cnt_q == CapCnt) begin
                capture = 1'b1;
                state_d = StHeld;
                cnt_d   = HeldCnt;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // FSM state, counter and previous key; clear forces the next key to look new.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= 8'd0;
            key_prev_q <= '1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            key_prev_q <= clear ? '1 : key;
        end
    end

    // Captured digit state, pulses and error counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q  <= 16'd0;
            valid_q   <= 4'd0;
            upd_q     <= 1'b0;
            upd_idx_q <= 2'd0;
            bad_q     <= 1'b0;
            err_q     <= 8'd0;
`ifdef SEG7_DP_CAPTURE_EN
            dp_q      <= 4'd0;
`endif
        end else if (clear) begin
            digits_q <= 16'd0;
            valid_q  <= 4'd0;
            upd_q    <= 1'b0;
            bad_q    <= 1'b0;
            err_q    <= 8'd0;
`ifdef SEG7_DP_CAPTURE_EN
            dp_q     <= 4'd0;
`endif
        end else begin
            upd_q <= capture;
            bad_q <= capture && !pat_legal && !pat_blank;
            if (capture) begin
                upd_idx_q    <= idx;
                valid_q[idx] <= pat_legal;
                if (pat_legal) begin
                    digits_q[4*idx +: 4] <= nib;
                end
                if (!pat_legal && !pat_blank && err_q != 8'hFF) begin
                    err_q <= err_q + 8'd1;
                end
`ifdef SEG7_DP_CAPTURE_EN
                if (pat_legal || pat_blank) begin
                    dp_q[idx] <= ~seg_s2_q[7];
                end
`endif
            end
        end
    end

    assign digits  = digits_q;
    assign valid   = valid_q;
    assign upd     = upd_q;
    assign upd_idx = upd_idx_q;
    assign bad_pat = bad_q;
    assign err_cnt = err_q;
`ifdef SEG7_DP_CAPTURE_EN
    assign dp      = dp_q;
`endif

endmodule

// File: tb/tb_seg7_capture_monitor.sv
// Directed bench for seg7_capture_monitor with STABLE_CYCLES=4. Expected captures are pushed
// to a scoreboard queue as stimulus is driven and popped when upd pulses.
module tb_seg7_capture_monitor;

    localparam int unsigned Stable = 4;

    localparam logic [6:0] Tbl [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic [1:0]  idx;
        logic [15:0] digits;
        logic [3:0]  valid;
        logic        bad;
        logic [7:0]  err;
        logic [3:0]  dp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        clear;
    logic [15:0] digits;
    logic [3:0]  valid;
    logic        upd;
    logic [1:0]  upd_idx;
    logic        bad_pat;
    logic [7:0]  err_cnt;
`ifdef SEG7_DP_CAPTURE_EN
    logic [3:0]  dp;
`endif

    int checks    = 0;
    int failures  = 0;
    int upd_count = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    logic [15:0] m_digits = '0;
    logic [3:0]  m_valid  = '0;
    logic [7:0]  m_err    = '0;
    logic [3:0]  m_dp     = '0;

    seg7_capture_monitor #(
        .STABLE_CYCLES(Stable)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .seg     (seg),
        .an      (an),
        .clear   (clear),
        .digits  (digits),
        .valid   (valid),
        .upd     (upd),
        .upd_idx (upd_idx),
        .bad_pat (bad_pat),
        .err_cnt (err_cnt)
`ifdef SEG7_DP_CAPTURE_EN
        ,
        .dp      (dp)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Returns {kind, nibble}: kind 0 = legal, 1 = blank, 2 = illegal.
    function automatic logic [5:0] ref_decode(input logic [6:0] p);
        if (p == 7'h7F) return {2'd1, 4'h0};
        for (int i = 0; i < 16; i++) begin
            if (Tbl[i] == p) return {2'd0, 4'(i)};
        end
        return {2'd2, 4'h0};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [7:0] s);
        an  = a;
        seg = s;
    endtask

    task automatic model_zero();
        m_digits = '0;
        m_valid  = '0;
        m_err    = '0;
        m_dp     = '0;
    endtask

    task automatic expect_capture(input logic [3:0] a, input logic [7:0] s);
        exp_t e;
        logic [1:0] i;
        logic [5:0] d;
        case (a)
            4'b1110: i = 2'd0;
            4'b1101: i = 2'd1;
            4'b1011: i = 2'd2;
            default: i = 2'd3;
        endcase
        d = ref_decode(s[6:0]);
        if (d[5:4] == 2'd0) begin
            m_digits[4*i +: 4] = d[3:0];
            m_valid[i] = 1'b1;
            m_dp[i] = ~s[7];
        end else if (d[5:4] == 2'd1) begin
            m_valid[i] = 1'b0;
            m_dp[i] = ~s[7];
        end else begin
            m_valid[i] = 1'b0;
            if (m_err != 8'hFF) m_err = m_err + 8'd1;
        end
        e.idx    = i;
        e.digits = m_digits;
        e.valid  = m_valid;
        e.bad    = (d[5:4] == 2'd2);
        e.err    = m_err;
        e.dp     = m_dp;
        exp_q.push_back(e);
    endtask

    // Bounded wait for all pending captures to be observed.
    task automatic drain(input string tag);
        int k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            tick(1);
            k++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    // Scoreboard: every upd pulse must match the oldest expected capture.
    always @(negedge clk) begin
        if (upd === 1'b1) begin
            upd_count++;
            if (exp_q.size() == 0) begin
                chk("unexpected_upd", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("upd_idx", upd_idx, mon_e.idx);
                chk("digits", digits, mon_e.digits);
                chk("valid", valid, mon_e.valid);
                chk("bad_pat", bad_pat, mon_e.bad);
                chk("err_cnt", err_cnt, mon_e.err);
`ifdef SEG7_DP_CAPTURE_EN
                chk("dp", dp, mon_e.dp);
`endif
            end
        end else if (bad_pat !== 1'b0) begin
            chk("bad_pat_stray", bad_pat, 0);
        end
    end

    initial begin
        int n0;
        rst_n = 1'b0;
        clear = 1'b0;
        drive(4'hF, 8'hFF);
        tick(3);
        chk("rst_digits", digits, 0);
        chk("rst_valid", valid, 0);
        chk("rst_upd", upd, 0);
        chk("rst_upd_idx", upd_idx, 0);
        chk("rst_bad", bad_pat, 0);
        chk("rst_err", err_cnt, 0);
        rst_n = 1'b1;
        tick(3);

        // Digit 0 shows '2': capture lands exactly after edge Stable+1.
        drive(4'b1110, 8'hA4);
        expect_capture(4'b1110, 8'hA4);
        tick(Stable + 1);
        chk("lat_early", upd, 0);
        tick(1);
        chk("lat_edge", upd, 1);
        drain("drain_d0");
        chk("d0_nib", digits[3:0], 4'h2);
        chk("d0_valid", valid, 4'b0001);

        // Short dwell of '4' is abandoned; only the following '5' is captured.
        n0 = upd_count;
        drive(4'b1011, 8'h99);
        tick(3);
        drive(4'b1011, 8'h92);
        expect_capture(4'b1011, 8'h92);
        tick(12);
        drain("drain_d2");
        chk("one_upd", upd_count - n0, 1);
        chk("d2_nib", digits[11:8], 4'h5);
        chk("d2_valid", valid[2], 1);

        // Digit 3: legal 'E', then blank, then an illegal pattern.
        drive(4'b0111, 8'h86);
        expect_capture(4'b0111, 8'h86);
        tick(8);
        drive(4'b0111, 8'hFF);
        expect_capture(4'b0111, 8'hFF);
        tick(8);
        drain("drain_blank");
        chk("blank_valid", valid[3], 0);
        drive(4'b0111, 8'h55);
        expect_capture(4'b0111, 8'h55);
        tick(8);
        drain("drain_bad");
        chk("bad_err", err_cnt, 1);
        chk("bad_keep", digits[15:12], 4'hE);

        // Two active anodes never capture.
        n0 = upd_count;
        drive(4'b1100, 8'h40);
        tick(100);
        chk("multi_an_no_upd", upd_count - n0, 0);

        // Error counter saturates.
        for (int i = 0; i < 256; i++) begin
            drive(4'b0111, (i % 2 == 0) ? 8'h55 : 8'h56);
            expect_capture(4'b0111, (i % 2 == 0) ? 8'h55 : 8'h56);
            tick(6);
        end
        drain("drain_sat");
        chk("err_sat", err_cnt, 8'hFF);

        // Clear in the capture cycle wins.
        n0 = upd_count;
        drive(4'b1110, 8'h80);
        tick(Stable + 1);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        drive(4'hF, 8'hFF);
        model_zero();
        chk("clr_upd", upd, 0);
        chk("clr_valid", valid, 0);
        chk("clr_err", err_cnt, 0);
        chk("clr_digits", digits, 0);
        tick(10);
        chk("clr_no_upd", upd_count - n0, 0);

        // Populate state, then reset in the middle of a dwell.
        drive(4'b1101, 8'h79);
        expect_capture(4'b1101, 8'h79);
        tick(8);
        drive(4'b1011, 8'h55);
        expect_capture(4'b1011, 8'h55);
        tick(8);
        drain("drain_pre_rst");
        drive(4'b1110, 8'h24);
        tick(3);
        #2;
        rst_n = 1'b0;
        #1;
        model_zero();
        chk("arst_digits", digits, 0);
        chk("arst_valid", valid, 0);
        chk("arst_err", err_cnt, 0);
        chk("arst_upd", upd, 0);
        tick(2);
        rst_n = 1'b1;
        expect_capture(4'b1110, 8'h24);
        tick(Stable + 1);
        chk("post_rst_early", upd, 0);
        tick(1);
        chk("post_rst_edge", upd, 1);
        drain("drain_post_rst");

        // '0' with dp lit on digit 1.
        drive(4'b1101, 8'h40);
        expect_capture(4'b1101, 8'h40);
        tick(8);
        drain("drain_dp");
        chk("d1_nib", digits[7:4], 4'h0);
        chk("d1_valid", valid[1], 1);
`ifdef SEG7_DP_CAPTURE_EN
        chk("d1_dp", dp[1], 1);
`endif

        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
